// File: rtl/fpu_addsub_param_if.sv
`timescale 1ns / 1ps
// fpu_addsub_param_if: operand/result handshake bundle for fpu_addsub_param.
// The master side issues operations and consumes results. The slave side is the adder.
interface fpu_addsub_param_if #(
    parameter int unsigned EXP_W = 6,
    parameter int unsigned MAN_W = 25
) ();

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] op_A_in;
    logic [W-1:0] op_B_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    modport master (
        output in_valid, op, op_A_in, op_B_in, out_ready,
        input  in_ready, out_valid, data_out, status_out
    );

    modport slave (
        input  in_valid, op, op_A_in, op_B_in, out_ready,
        output in_ready, out_valid, data_out, status_out
    );

endinterface

// File: rtl/fpu_addsub_param.sv
`timescale 1ns / 1ps
// fpu_addsub_param: parametrised multi-cycle floating-point add/subtract, one op in flight.
// Word format {sign, exp[EXP_W], frac[MAN_W]}; exp 0 encodes zero (no denormals),
// exp all-ones is the overflow/saturation code.
// Optional macro FPU_RNE_EN: round to nearest, ties to even. Undefined: truncate.
module fpu_addsub_param #(
    parameter int unsigned EXP_W = 6,
    parameter int unsigned MAN_W = 25
) (
    input  logic              clock100KHz,
    input  logic              reset,
    fpu_addsub_param_if.slave bus
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    // Extended mantissa: {hidden, frac, G, R, S}
    localparam int unsigned XW = MAN_W + 4;
    // One spare exponent bit so a carry out of the top code never wraps
    localparam int unsigned EW = EXP_W + 1;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StOperate,
        StNormalize,
        StRound,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [XW-1:0] ma_q, ma_d;
    logic [XW-1:0] mb_q, mb_d;
    logic [XW:0]   man_q, man_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          sign_q, sign_d;
    logic [W-1:0]  data_q, data_d;
    logic [3:0]    status_q, status_d;

    logic [EW-1:0] ea, eb, diff;
    logic [XW-1:0] xa, xb, shv, shv_out;
    logic          a_big;

    logic             g, rs, inexact, inc;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] frac;
    logic [EW-1:0]    exp_r;

    // Alignment: unpack both operands and right-shift the smaller-exponent one with sticky.
    always_comb begin
        ea      = {1'b0, a_q[W-2:MAN_W]};
        eb      = {1'b0, b_q[W-2:MAN_W]};
        xa      = {|a_q[W-2:MAN_W], a_q[MAN_W-1:0], 3'b000};
        xb      = {|b_q[W-2:MAN_W], b_q[MAN_W-1:0], 3'b000};
        a_big   = (ea >= eb);
        diff    = a_big ? (ea - eb) : (eb - ea);
        shv     = a_big ? xb : xa;
        shv_out = '0;
        if (32'(diff) > MAN_W + 3) begin
            // Shifted entirely past S: only the sticky survives
            shv_out[0] = |shv;
        end else begin
            shv_out    = shv >> diff;
            shv_out[0] = shv_out[0] | (|(shv & ~({XW{1'b1}} << diff)));
        end
    end

    // Rounding: decide the increment from G/R/S and fold a mantissa carry into the exponent.
    always_comb begin
        g       = man_q[2];
        rs      = man_q[1] | man_q[0];
        inexact = g | rs;
`ifdef FPU_RNE_EN
        inc     = g & (rs | man_q[3]);
`else
        inc     = 1'b0;
`endif
        rnd     = {1'b0, man_q[XW-1:3]} + {{(MAN_W + 1){1'b0}}, inc};
        if (rnd[MAN_W+1]) begin
            frac  = rnd[MAN_W:1];
            exp_r = exp_q + EXP_ONE;
        end else begin
            frac  = rnd[MAN_W-1:0];
            exp_r = exp_q;
        end
    end

    // FSM next state and datapath next values.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        man_d    = man_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        data_d   = data_q;
        status_d = status_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.op_A_in;
                    // Subtraction is addition with B's sign flipped
                    b_d     = {bus.op_B_in[W-1] ^ bus.op, bus.op_B_in[W-2:0]};
                    state_d = StAlign;
                end
            end
            StAlign: begin
                exp_d   = a_big ? ea : eb;
                ma_d    = a_big ? xa : shv_out;
                mb_d    = a_big ? shv_out : xb;
                state_d = StOperate;
            end
            StOperate: begin
                if (a_q[W-1] == b_q[W-1]) begin
                    man_d  = {1'b0, ma_q} + {1'b0, mb_q};
                    sign_d = a_q[W-1];
                end else if (ma_q >= mb_q) begin
                    man_d  = {1'b0, ma_q - mb_q};
                    sign_d = (ma_q == mb_q) ? 1'b0 : a_q[W-1];
                end else begin
                    man_d  = {1'b0, mb_q - ma_q};
                    sign_d = b_q[W-1];
                end
                state_d = StNormalize;
            end
            StNormalize: begin
                if (man_q == '0) begin
                    data_d   = '0;
                    status_d = 4'b0001;
                    state_d  = StDone;
                end else if (man_q[XW]) begin
                    man_d = {1'b0, man_q[XW:2], man_q[1] | man_q[0]};
                    exp_d = exp_q + EXP_ONE;
                end else if (!man_q[XW-1]) begin
                    if (exp_q <= EXP_ONE) begin
                        // No denormals: flush to signed zero
                        data_d   = {sign_q, {(W - 1){1'b0}}};
                        status_d = 4'b1010;
                        state_d  = StDone;
                    end else begin
                        man_d = man_q << 1;
                        exp_d = exp_q - EXP_ONE;
                    end
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (exp_r >= EXP_MAX) begin
                    data_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    status_d = 4'b0110;
                end else begin
                    data_d   = {sign_q, exp_r[EXP_W-1:0], frac};
                    status_d = {2'b00, inexact, ~inexact};
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            man_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            man_q    <= man_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;

endmodule

// File: doc/fpu_addsub_param.md
Name: fpu_addsub_param

Overview:
- Parametrised floating-point add/subtract unit; next generation of the team's single-format multi-cycle adder.
- Adds configurable exponent/mantissa widths, an add/sub opcode, valid/ready handshakes on both sides, guard/round/sticky tracking and an inexact flag.
- Sits between the operand register file and the result writeback in the datapath. One operation in flight at a time.

Parameters:
- EXP_W, 6, exponent field width.
- MAN_W, 25, stored mantissa (fraction) width. Word width W = 1+EXP_W+MAN_W (32 at defaults).

Ports:
- clock100KHz  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept an operation
- op  in  1  0 = A+B, 1 = A-B
- op_A_in  in  W  {sign, exp, mant}
- op_B_in  in  W  {sign, exp, mant}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- data_out  out  W  result word
- status_out  out  4  [3] underflow, [2] overflow, [1] inexact, [0] exact

Behaviour:
- Reset (async, active-high) clears everything immediately:
  - state = IDLE; in_ready = 1; out_valid = 0; data_out = 0; status_out = 0; all internal registers 0.
  - Reset mid-operation discards the operation.
- Encoding:
  - Exp field 0 means zero; mantissa ignored, hidden bit 0; no denormals.
  - Otherwise hidden bit = 1.
  - Exp all-ones is the overflow/saturation code.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, capture operands, B sign ^= op, go to ALIGN. in_ready = 0 from the next cycle until the result is taken.
  - ALIGN: larger exponent becomes the result exponent. Smaller operand right-shifted by the difference into an extended mantissa {hidden, MAN_W frac, G, R, S}; bits shifted past S are OR-ed into S. Difference > MAN_W+3: mantissa becomes 0 with S = 1 (if that operand is nonzero). Go to OPERATE.
  - OPERATE:
    - Equal signs: add magnitudes, sign = A sign.
    - Otherwise: subtract smaller from larger magnitude, sign of the larger; equal magnitudes give +0.
    - Sum width MAN_W+5 (carry bit). Go to NORMALIZE.
  - NORMALIZE: one action per cycle.
    - Carry set: shift right 1 with sticky OR, exp+1.
    - Else if the hidden position is 0 and the mantissa is nonzero: shift left 1, exp-1.
    - Else (normalized): go to ROUND.
    - Zero mantissa: result +0, go to DONE.
    - Exp would drop below 1: flush to signed zero, underflow = 1, inexact = 1, go to DONE.
  - ROUND:
    - Rounding mode per the Optional Feature.
    - Mantissa increment carry-out: shift right, exp+1.
    - Exp reaches 2^EXP_W-1 (at any point): saturate to {sign, all-ones, 0}, overflow = 1, inexact = 1.
    - inexact = G|R|S before rounding. Go to DONE.
  - DONE: out_valid = 1; data_out/status_out stable. On out_ready, out_valid drops and the FSM returns to IDLE (in_ready = 1 next cycle).
- status_out:
  - exact = 1 iff the other three flags are 0.
  - Status values held until the next result.
- Latency: accept to out_valid = 5 cycles plus one per NORMALIZE shift. Worst case 5+MAN_W+1.
- Simultaneous out_ready and new in_valid in DONE: the new op is not accepted that cycle.

Optional Feature:
- Macro FPU_RNE_EN.
- Defined: round to nearest, ties to even.
  - Increment when G & (R|S|LSB).
- Undefined: truncate (round toward zero).
  - No increment.
  - inexact still reported from G|R|S.
  - Overflow from rounding cannot occur.

Test Plan:
- Default widths, op=0, A=0x14000000, B=0x14000000 -> data_out 0x16000000, status 0001, out_valid 6 cycles after accept.
- op=1, A=0x14000000, B=0x14000000 -> data_out 0x00000000, status 0001.
- op=0, A=0x7C000000, B=0x7C000000 -> data_out 0x7E000000, status 0110.
- Rounding, op=0:
  - A=0x3C000000, B=0x08000000 -> 0x3C000000, status 0010 (tie, even).
  - A=0x3C000000, B=0x08000001 -> RNE gives 0x3C000001; truncate gives 0x3C000000; status 0010 in both cases.
- op=0, A=0x02000000, B=0x82000001 -> data_out 0x80000000, status 1010.
- Handshake/reset:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and data held, in_ready=0, in_valid ignored.
  - Assert reset during NORMALIZE -> out_valid=0, in_ready=1, data_out=0 immediately.
  - Next op completes correctly.
